// File: rtl/rt_line_seq_ctrl.sv
// Four-track racetrack line (data, mask, program, LiM) with shift alignment controller and req/rsp handshake.
// Optional statistics counters enabled by defining RT_LINE_STATS_EN.
module rt_line_seq_ctrl #(
  parameter int NB        = 32,
  parameter int NP        = 8,
  parameter int SHIFT_LAT = 1,
  localparam int NSP      = NB / NP,
  localparam int NOV      = NSP - 1,
  localparam int L        = NB + NOV,
  localparam int OW       = $clog2(NSP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [1:0]    req_op_i,
  input  logic [OW-1:0] req_offset_i,
  input  logic [NP-1:0] wdata_i,
  input  logic [NP-1:0] wmask_i,
  input  logic [NP-1:0] wprog_i,
  input  logic [NP-1:0] wen_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [NP-1:0] rsp_data_o,
  output logic [NP-1:0] rsp_mask_o,
  output logic [NP-1:0] rsp_prog_o,
  output logic [NP-1:0] rsp_lim_o,
  output logic [OW-1:0] pos_o
`ifdef RT_LINE_STATS_EN
  ,
  output logic [31:0]   shift_cnt_o,
  output logic [31:0]   access_cnt_o
`endif
);

  localparam int SCW = (SHIFT_LAT > 1) ? $clog2(SHIFT_LAT) : 1;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_LIM   = 2'b10,
    OP_HOME  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state_q, state_nxt;

  op_t           op_q;
  logic [OW-1:0] tgt_q;
  logic [OW-1:0] pos_q;
  logic [SCW-1:0] step_q;
  logic [NP-1:0] wdata_q, wmask_q, wprog_q, wen_q;

  logic [L-1:0]  data_q, mask_q, prog_q, lim_q;
  logic [L-1:0]  data_acc, mask_acc, prog_acc, lim_acc;
  logic [NP-1:0] rsp_data_n, rsp_mask_n, rsp_prog_n, rsp_lim_n;

  logic          accept;
  logic [OW-1:0] tgt_in;
  logic          shift_en;
  logic          shift_back;
  logic [OW-1:0] pos_step;

  assign accept     = req_valid_i && (state_q == S_IDLE);
  assign tgt_in     = (op_t'(req_op_i) == OP_HOME) ? '0 : req_offset_i;
  assign shift_back = (pos_q < tgt_q);
  assign pos_step   = shift_back ? pos_q + 1'b1 : pos_q - 1'b1;
  assign pos_o      = pos_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt   = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    shift_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = (pos_q != tgt_in) ? S_ALIGN : S_ACCESS;
      end
      S_ALIGN: begin
        shift_en = (step_q == SCW'(SHIFT_LAT - 1));
        if (shift_en && (pos_step == tgt_q)) state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Post-access track image; the response is taken from it so a write is visible in its own reply.
  always_comb begin
    data_acc = data_q;
    mask_acc = mask_q;
    prog_acc = prog_q;
    lim_acc  = lim_q;
    case (op_q)
      OP_WRITE: begin
        for (int p = 0; p < NP; p++) begin
          if (wen_q[p]) begin
            data_acc[p*NSP+NOV] = wdata_q[p];
            mask_acc[p*NSP+NOV] = wmask_q[p];
            prog_acc[p*NSP+NOV] = wprog_q[p];
          end
        end
      end
      OP_LIM:  lim_acc = (prog_q & ~(data_q | mask_q)) | (~prog_q & ~(data_q & mask_q));
      default: ;
    endcase
    for (int p = 0; p < NP; p++) begin
      rsp_data_n[p] = data_acc[p*NSP+NOV];
      rsp_mask_n[p] = mask_acc[p*NSP+NOV];
      rsp_prog_n[p] = prog_acc[p*NSP+NOV];
      rsp_lim_n[p]  = lim_acc[p*NSP+NOV];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q       <= OP_READ;
      tgt_q      <= '0;
      pos_q      <= '0;
      step_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wprog_q    <= '0;
      wen_q      <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      prog_q     <= '0;
      lim_q      <= '0;
      rsp_data_o <= '0;
      rsp_mask_o <= '0;
      rsp_prog_o <= '0;
      rsp_lim_o  <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_t'(req_op_i);
        tgt_q   <= tgt_in;
        wdata_q <= wdata_i;
        wmask_q <= wmask_i;
        wprog_q <= wprog_i;
        wen_q   <= wen_i;
        step_q  <= '0;
      end
      if (state_q == S_ALIGN) begin
        if (shift_en) begin
          // Moving toward higher pos pulls cells down; the vacated end fills with zero.
          step_q <= '0;
          pos_q  <= pos_step;
          data_q <= shift_back ? (data_q >> 1) : (data_q << 1);
          mask_q <= shift_back ? (mask_q >> 1) : (mask_q << 1);
          prog_q <= shift_back ? (prog_q >> 1) : (prog_q << 1);
          lim_q  <= shift_back ? (lim_q  >> 1) : (lim_q  << 1);
        end else begin
          step_q <= step_q + 1'b1;
        end
      end
      if (state_q == S_ACCESS) begin
        data_q     <= data_acc;
        mask_q     <= mask_acc;
        prog_q     <= prog_acc;
        lim_q      <= lim_acc;
        rsp_data_o <= rsp_data_n;
        rsp_mask_o <= rsp_mask_n;
        rsp_prog_o <= rsp_prog_n;
        rsp_lim_o  <= rsp_lim_n;
      end
    end
  end

`ifdef RT_LINE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_cnt_o  <= '0;
      access_cnt_o <= '0;
    end else begin
      if (shift_en && (shift_cnt_o != 32'hFFFF_FFFF)) shift_cnt_o <= shift_cnt_o + 32'd1;
      if ((state_q == S_ACCESS) && (access_cnt_o != 32'hFFFF_FFFF)) access_cnt_o <= access_cnt_o + 32'd1;
    end
  end
`endif

endmodule
